// File: rtl/fp_seq_pkg.sv
// Shared types and phase-path table for the F-PM phase sequencer.
package fp_seq_pkg;

    typedef enum logic [1:0] {IDLE, CLR, PHASE, DONE} top_state_t;
    typedef enum logic [1:0] {S1, GAP, S2} sub_step_t;

    localparam logic [3:0] F_NONE = 4'd0;
    localparam logic [3:0] F1  = 4'd1;
    localparam logic [3:0] F2  = 4'd2;
    localparam logic [3:0] F3  = 4'd3;
    localparam logic [3:0] F4  = 4'd4;
    localparam logic [3:0] F5  = 4'd5;
    localparam logic [3:0] F6  = 4'd6;
    localparam logic [3:0] F7  = 4'd7;
    localparam logic [3:0] F8  = 4'd8;
    localparam logic [3:0] F9  = 4'd9;
    localparam logic [3:0] F10 = 4'd10;
    localparam logic [3:0] F11 = 4'd11;
    localparam logic [3:0] F12 = 4'd12;
    localparam logic [3:0] F13 = 4'd13;

    localparam int OP_AD  = 0;
    localparam int OP_SD  = 1;
    localparam int OP_MW  = 2;
    localparam int OP_DW  = 3;
    localparam int OP_AF  = 4;
    localparam int OP_SF  = 5;
    localparam int OP_MF  = 6;
    localparam int OP_DF  = 7;
    localparam int OP_NRF = 8;
    localparam int N_OPS  = 9;

    // Phase that follows ph once its loop (if any) is finished; F_NONE ends the op.
    function automatic logic [3:0] next_phase(input logic [N_OPS-1:0] op,
                                              input logic [3:0]       ph);
        logic [3:0] nxt;
        logic       fadd;
        nxt  = F_NONE;
        fadd = op[OP_AF] | op[OP_SF];
        case (ph)
            F1:      nxt = (op[OP_AD] | op[OP_SD]) ? F7 : (op[OP_NRF] ? F8 : F2);
            F2:      nxt = fadd ? F3 : F4;
            F3:      nxt = F4;
            F4:      nxt = fadd ? F5 : F6;
            F5:      nxt = F8;
            F6:      nxt = op[OP_MW] ? F10 : (op[OP_DW] ? F7 : F8);
            F7:      nxt = F10;
            F8:      nxt = op[OP_DF] ? F9 : F13;
            F9:      nxt = F13;
            default: nxt = F_NONE;
        endcase
        return nxt;
    endfunction

    function automatic logic is_loop_phase(input logic [3:0] ph);
        return (ph == F3) || (ph == F6) || (ph == F8);
    endfunction

endpackage

// File: rtl/fp_strobe.sv
// Per-phase strobe timing: S1 (strob_fp_ low), STROB_GAP idle cycles, S2 (strob2_fp high).
module fp_strobe
    import fp_seq_pkg::*;
#(
    parameter int STROB_GAP = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic i_go,
    output logic o_strob_n,
    output logic o_strob2,
    output logic o_last
);

    localparam logic [3:0] GAP_LAST = 4'(STROB_GAP - 1);

    logic      r_active;
    sub_step_t r_step;
    logic [3:0] r_gap;

    logic      w_active_next;
    sub_step_t w_step_next;
    logic [3:0] w_gap_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_active <= 1'b0;
            r_step   <= S1;
            r_gap    <= 4'd0;
        end else begin
            r_active <= w_active_next;
            r_step   <= w_step_next;
            r_gap    <= w_gap_next;
        end
    end

    // A go pulse is honoured when idle or in S2, so phases chain with no dead cycle.
    always_comb begin
        w_active_next = r_active;
        w_step_next   = r_step;
        w_gap_next    = r_gap;
        if (!r_active || r_step == S2) begin
            w_active_next = i_go;
            w_step_next   = S1;
            w_gap_next    = 4'd0;
        end else if (r_step == S1) begin
            w_step_next = GAP;
            w_gap_next  = 4'd0;
        end else if (r_gap == GAP_LAST) begin
            w_step_next = S2;
        end else begin
            w_gap_next = r_gap + 4'd1;
        end
    end

    assign o_strob_n = !(r_active && r_step == S1);
    assign o_strob2  = r_active && (r_step == S2);
    assign o_last    = r_active && (r_step == S2);

endmodule

// File: rtl/fp_seq.sv
// F-PM phase sequencer: walks the op-specific F1..F13 path, handles loop phases and aborts.
module fp_seq
    import fp_seq_pkg::*;
#(
    parameter int STROB_GAP = 2,
    parameter int MAX_LOOP  = 64
) (
    input  logic        __clk,
    input  logic        clr,
    input  logic        start,
    input  logic        ad,
    input  logic        sd,
    input  logic        mw,
    input  logic        dw,
    input  logic        af,
    input  logic        sf,
    input  logic        mf,
    input  logic        df,
    input  logic        nrf,
    input  logic        fic,
    input  logic        end_,
    input  logic        di,
    output logic [12:0] f_,
    output logic        strob_fp_,
    output logic        strob2_fp,
    output logic        _0_f_,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int             CW        = $clog2(MAX_LOOP) + 1;
    localparam logic [CW-1:0] LOOP_LAST = CW'(MAX_LOOP - 1);

    top_state_t       r_state;
    logic [3:0]       r_phase;
    logic [N_OPS-1:0] r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_err;

    top_state_t       w_state_next;
    logic [3:0]       w_phase_next;
    logic [N_OPS-1:0] w_op_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_err_next;

    logic [N_OPS-1:0] w_op_in;
    logic [3:0]       w_path_next;
    logic             w_go;
    logic             w_last;
    logic             w_div_op;
    logic             w_early_end;
    logic             w_div_err;
    logic             w_repeat;

    assign w_op_in     = {nrf, df, mf, sf, af, dw, mw, sd, ad};
    assign w_path_next = next_phase(r_op, r_phase);
    assign w_div_op    = r_op[OP_DW] | r_op[OP_DF];
    assign w_div_err   = w_div_op && di && (r_phase == F6 || r_phase == F7);
    assign w_early_end = w_div_op && (r_phase == F6) && !end_;
    assign w_repeat    = is_loop_phase(r_phase) && fic && !w_early_end;

    fp_strobe #(
        .STROB_GAP (STROB_GAP)
    ) u_strobe (
        .clk       (__clk),
        .srst      (clr),
        .i_go      (w_go),
        .o_strob_n (strob_fp_),
        .o_strob2  (strob2_fp),
        .o_last    (w_last)
    );

    always_ff @(posedge __clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_phase <= F_NONE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_op    <= w_op_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_op_next    = r_op;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_go         = 1'b0;
        case (r_state)
            IDLE: begin
                w_err_next = 1'b0;
                w_cnt_next = '0;
                if (start) begin
                    if ($countones(w_op_in) == 1) begin
                        w_op_next    = w_op_in;
                        w_state_next = CLR;
                    end else begin
                        w_state_next = DONE;
                        w_err_next   = 1'b1;
                    end
                end
            end
            CLR: begin
                w_go         = 1'b1;
                w_state_next = PHASE;
                w_phase_next = F1;
                w_cnt_next   = '0;
            end
            PHASE: begin
                // Everything is decided in the S2 cycle; other sub-steps just hold.
                if (w_last) begin
                    if (w_div_err) begin
                        w_state_next = DONE;
                        w_err_next   = 1'b1;
                    end else if (w_repeat) begin
                        if (r_cnt == LOOP_LAST) begin
                            w_state_next = DONE;
                            w_err_next   = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                            w_go       = 1'b1;
                        end
                    end else if (w_path_next == F_NONE) begin
                        w_state_next = DONE;
                        w_err_next   = 1'b0;
                    end else begin
                        w_phase_next = w_path_next;
                        w_cnt_next   = '0;
                        w_go         = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 13; gi++) begin : g_fline
            assign f_[gi] = !((r_state == PHASE) && (r_phase == 4'(gi + 1)));
        end
    endgenerate

    assign _0_f_ = !(r_state == CLR);
    assign busy  = (r_state == CLR) || (r_state == PHASE);
    assign done  = (r_state == DONE);
    assign err   = (r_state == DONE) && r_err;

endmodule

// File: tb/tb_fp_seq.sv
// Directed bench for fp_seq: phase sequences, strobe shape, latency, loops and aborts.
module tb_fp_seq;

    localparam int G  = 2;
    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic        ad = 0, sd = 0, mw = 0, dw = 0, af = 0, sf = 0, mf = 0, df = 0, nrf = 0;
    logic        fic = 1'b0;
    logic        end_ = 1'b1;
    logic        di = 1'b0;
    logic [12:0] f_;
    logic        strob_fp_, strob2_fp, _0_f_, busy, done, err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] tr_seq;
    int tr_done_t, tr_err, tr_clrp, tr_shape, tr_nph;
    int fic_n[14];
    int endlow_at[14];
    int di_at[14];

    always #5 clk = ~clk;

    fp_seq #(.STROB_GAP(G), .MAX_LOOP(ML)) dut (
        .__clk(clk), .clr(clr), .start(start),
        .ad(ad), .sd(sd), .mw(mw), .dw(dw), .af(af), .sf(sf), .mf(mf), .df(df), .nrf(nrf),
        .fic(fic), .end_(end_), .di(di),
        .f_(f_), .strob_fp_(strob_fp_), .strob2_fp(strob2_fp), ._0_f_(_0_f_),
        .busy(busy), .done(done), .err(err)
    );

    function automatic int ph_of(input logic [12:0] f);
        int n;
        int idx;
        n = 0;
        idx = 0;
        for (int i = 0; i < 13; i++) begin
            if (f[i] == 1'b0) begin
                n++;
                idx = i + 1;
            end
        end
        if (n > 1) return 15;
        return idx;
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < 14; i++) begin
            fic_n[i] = 0;
            endlow_at[i] = 0;
            di_at[i] = 0;
        end
    endtask

    // Issues one start, then records the phase trace until done (or a 300-cycle bound).
    task automatic run_op(input logic [8:0] op);
        int s2c[14];
        int pos;
        int cur;
        int prev;
        for (int i = 0; i < 14; i++) s2c[i] = 0;
        tr_seq = '0; tr_done_t = -1; tr_err = -1; tr_clrp = 0; tr_shape = 0; tr_nph = 0;
        pos = 0; prev = 0;
        @(negedge clk);
        {nrf, df, mf, sf, af, dw, mw, sd, ad} = op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        {nrf, df, mf, sf, af, dw, mw, sd, ad} = 9'h000;
        for (int t = 1; t <= 300; t++) begin
            cur = ph_of(f_);
            if (_0_f_ == 1'b0) tr_clrp++;
            if (done) begin
                tr_done_t = t;
                tr_err = int'(err);
                if (f_ !== 13'h1FFF || busy !== 1'b0) tr_shape++;
                if (tr_nph > 0 && pos != G + 1) tr_shape++;
                break;
            end
            fic = 1'b0; end_ = 1'b1; di = 1'b0;
            if (cur == 15) begin
                tr_shape++;
            end else if (cur != 0) begin
                if (strob_fp_ == 1'b0) begin
                    if (tr_nph > 0 && pos != G + 1) tr_shape++;
                    pos = 0;
                    tr_seq = {tr_seq[123:0], 4'(cur)};
                    tr_nph++;
                end else begin
                    pos++;
                    if (cur != prev) tr_shape++;
                end
                if (strob2_fp !== (pos == G + 1)) tr_shape++;
                if (busy !== 1'b1) tr_shape++;
                if (strob2_fp) begin
                    s2c[cur]++;
                    fic  = (s2c[cur] <= fic_n[cur]);
                    end_ = !(endlow_at[cur] == s2c[cur]);
                    di   = (di_at[cur] == s2c[cur]);
                end
            end
            prev = cur;
            @(negedge clk);
        end
        fic = 1'b0; end_ = 1'b1; di = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int act;
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (f_ !== 13'h1FFF) $display("FAIL reset_f: got %h want 1fff", f_); else n_pass++;
        n_checks++;
        if ({strob_fp_, strob2_fp, _0_f_} !== 3'b101)
            $display("FAIL reset_strobes: got %b want 101", {strob_fp_, strob2_fp, _0_f_});
        else n_pass++;
        n_checks++;
        if ({busy, done, err} !== 3'b000)
            $display("FAIL reset_handshake: got %b want 000", {busy, done, err});
        else n_pass++;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (f_ !== 13'h1FFF || strob_fp_ !== 1'b1 || strob2_fp !== 1'b0 ||
                _0_f_ !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) act++;
        end
        n_checks++;
        if (act !== 0) $display("FAIL idle_quiet: got %0d active cycles want 0", act); else n_pass++;
    endtask

    task automatic test_fixed_add();
        clear_plan();
        run_op(9'h001);
        n_checks++;
        if (tr_seq !== 128'h17A) $display("FAIL ad_seq: got %0h want 17a", tr_seq); else n_pass++;
        n_checks++;
        if (tr_done_t !== 14) $display("FAIL ad_latency: got %0d want 14", tr_done_t); else n_pass++;
        n_checks++;
        if (tr_err !== 0) $display("FAIL ad_err: got %0d want 0", tr_err); else n_pass++;
        n_checks++;
        if (tr_clrp !== 1) $display("FAIL ad_clr_pulse: got %0d want 1", tr_clrp); else n_pass++;
        n_checks++;
        if (tr_shape !== 0) $display("FAIL ad_shape: got %0d errors want 0", tr_shape); else n_pass++;
        clear_plan();
        run_op(9'h002);
        n_checks++;
        if (tr_seq !== 128'h17A || tr_done_t !== 14)
            $display("FAIL sd_run: got seq %0h t %0d want 17a t 14", tr_seq, tr_done_t);
        else n_pass++;
    endtask

    task automatic test_float_loops();
        clear_plan();
        fic_n[3] = 2;
        fic_n[8] = 3;
        run_op(9'h010);
        n_checks++;
        if (tr_seq !== 128'h12333458888D)
            $display("FAIL af_seq: got %0h want 12333458888d", tr_seq);
        else n_pass++;
        n_checks++;
        if (tr_done_t !== 50 || tr_err !== 0)
            $display("FAIL af_done: got t %0d err %0d want t 50 err 0", tr_done_t, tr_err);
        else n_pass++;
        n_checks++;
        if (tr_shape !== 0) $display("FAIL af_shape: got %0d errors want 0", tr_shape); else n_pass++;
        clear_plan();
        run_op(9'h100);
        n_checks++;
        if (tr_seq !== 128'h18D || tr_done_t !== 14)
            $display("FAIL nrf_run: got seq %0h t %0d want 18d t 14", tr_seq, tr_done_t);
        else n_pass++;
    endtask

    task automatic test_division();
        clear_plan();
        fic_n[6] = 99;
        endlow_at[6] = 2;
        run_op(9'h080);
        n_checks++;
        if (tr_seq !== 128'h1246689D) $display("FAIL df_early_seq: got %0h want 1246689d", tr_seq);
        else n_pass++;
        n_checks++;
        if (tr_done_t !== 34 || tr_err !== 0)
            $display("FAIL df_early_done: got t %0d err %0d want t 34 err 0", tr_done_t, tr_err);
        else n_pass++;
        clear_plan();
        di_at[6] = 1;
        run_op(9'h080);
        n_checks++;
        if (tr_seq !== 128'h1246) $display("FAIL df_di_seq: got %0h want 1246", tr_seq); else n_pass++;
        n_checks++;
        if (tr_done_t !== 18 || tr_err !== 1)
            $display("FAIL df_di_done: got t %0d err %0d want t 18 err 1", tr_done_t, tr_err);
        else n_pass++;
    endtask

    task automatic test_loop_overflow();
        clear_plan();
        fic_n[6] = 99;
        run_op(9'h004);
        n_checks++;
        if (tr_seq !== 128'h1246666) $display("FAIL ovf_seq: got %0h want 1246666", tr_seq); else n_pass++;
        n_checks++;
        if (tr_done_t !== 30 || tr_err !== 1)
            $display("FAIL ovf_done: got t %0d err %0d want t 30 err 1", tr_done_t, tr_err);
        else n_pass++;
        n_checks++;
        if (tr_shape !== 0) $display("FAIL ovf_shape: got %0d errors want 0", tr_shape); else n_pass++;
    endtask

    task automatic test_abort();
        int found;
        int bad;
        clear_plan();
        found = 0;
        @(negedge clk);
        mf = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mf = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (f_[3] == 1'b0 && strob_fp_ == 1'b1 && strob2_fp == 1'b0) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (found !== 1) $display("FAIL abort_reach_f4_gap: got %0d want 1", found); else n_pass++;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if ({f_, strob_fp_, strob2_fp, _0_f_, busy, done, err} !== {13'h1FFF, 6'b101000})
            $display("FAIL abort_outputs: got %h %b want 1fff 101000", f_,
                     {strob_fp_, strob2_fp, _0_f_, busy, done, err});
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || f_ !== 13'h1FFF) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL abort_no_done: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_bad_decode();
        clear_plan();
        run_op(9'h030);
        n_checks++;
        if (tr_done_t !== 1 || tr_err !== 1)
            $display("FAIL bad_decode_done: got t %0d err %0d want t 1 err 1", tr_done_t, tr_err);
        else n_pass++;
        n_checks++;
        if (tr_clrp !== 0 || tr_nph !== 0)
            $display("FAIL bad_decode_quiet: got clr %0d phases %0d want 0 0", tr_clrp, tr_nph);
        else n_pass++;
        clear_plan();
        run_op(9'h000);
        n_checks++;
        if (tr_done_t !== 1 || tr_err !== 1)
            $display("FAIL no_op_done: got t %0d err %0d want t 1 err 1", tr_done_t, tr_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fixed_add();
        test_float_loops();
        test_division();
        test_loop_overflow();
        test_abort();
        test_bad_decode();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
